// File: rtl/systolic_feeder.sv
// ============================================================================
// systolic_feeder
// ----------------------------------------------------------------------------
// Drive-side sequencer for a 2x2 output-stationary systolic matrix array.
//
// One operand pair (A: 2xK, B: Kx2, signed DATA_W elements) is accepted per
// transaction over a valid/ready handshake. The block then:
//   1. FEED  : emits skewed row/column streams plus per-PE load strobes,
//   2. DRAIN : waits RESULT_LAT cycles for the array pipeline to settle,
//   3. DONE  : presents the captured {c11,c12,c21,c22} on a valid/ready port.
// Only one transaction is ever in flight; in_ready is low from accept until
// the cycle after the result handshake.
//
// Ports
//   clk                     rising-edge clock
//   reset                   synchronous, active-high
//   in_valid / in_ready     operand handshake
//   in_a                    A row-major,    A[i][k] at [(i*K+k)*DATA_W +: DATA_W]
//   in_b                    B column-major, B[k][j] at [(j*K+k)*DATA_W +: DATA_W]
//   a1X, a2X                row streams into array rows 1 and 2
//   bX1, bX2                column streams into array columns 1 and 2
//   push11                  load strobe for PE(1,1)
//   pushedge                load strobe for PE(1,2) and PE(2,1)
//   push22                  load strobe for PE(2,2)
//   c11, c12, c21, c22      accumulator outputs from the array
//   out_valid / out_ready   result handshake
//   out_c                   {c11,c12,c21,c22}, c11 in the MSBs
//
// Stream schedule during FEED (cnt = 0 .. max(K,2)):
//   a1X = A[0][cnt],   bX1 = B[cnt][0]     for cnt <  K, else 0
//   a2X = A[1][cnt-1], bX2 = B[cnt-1][1]   for 1 <= cnt <= K, else 0
//   push11 at cnt=0, pushedge at cnt=1, push22 at cnt=2
// Every stream/strobe is a register whose value for feed cycle cnt is
// computed from the next-state values, so it is valid during that cycle.
// Outside FEED all streams are 0, which leaves the array accumulators
// unchanged.
// ============================================================================
module systolic_feeder #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 32,
    parameter int K          = 2,
    parameter int RESULT_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*K*DATA_W-1:0]    in_a,
    input  logic [2*K*DATA_W-1:0]    in_b,

    output logic [DATA_W-1:0]        a1X,
    output logic [DATA_W-1:0]        a2X,
    output logic [DATA_W-1:0]        bX1,
    output logic [DATA_W-1:0]        bX2,
    output logic                     push11,
    output logic                     pushedge,
    output logic                     push22,

    input  logic [ACC_W-1:0]         c11,
    input  logic [ACC_W-1:0]         c12,
    input  logic [ACC_W-1:0]         c21,
    input  logic [ACC_W-1:0]         c22,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4*ACC_W-1:0]       out_c
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // FEED always runs to at least cnt=2 so that push22 fires even for K=1
    // (PE(2,2) receives its data through the array's internal skew registers).
    localparam int FEED_LAST  = (K < 2) ? 2 : K;
    localparam int DRAIN_LAST = (RESULT_LAT > 1) ? RESULT_LAT - 1 : 0;
    localparam int CNT_MAX    = (FEED_LAST > DRAIN_LAST) ? FEED_LAST : DRAIN_LAST;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    // Lookup tables are sized to the full counter range so a counter-indexed
    // read never needs a width adaptation; unused entries read as 0.
    localparam int CNT_DEPTH  = 1 << CNT_W;
    localparam int OP_W       = 2 * K * DATA_W;

    localparam logic [CNT_W-1:0] FEED_LAST_C  = CNT_W'(FEED_LAST);
    localparam logic [CNT_W-1:0] DRAIN_LAST_C = CNT_W'(DRAIN_LAST);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO      = CNT_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t                 state_reg,     state_next;
    logic [CNT_W-1:0]       cnt_reg,       cnt_next;
    logic [OP_W-1:0]        op_a_reg,      op_a_next;
    logic [OP_W-1:0]        op_b_reg,      op_b_next;
    logic [DATA_W-1:0]      a1x_reg,       a1x_next;
    logic [DATA_W-1:0]      a2x_reg,       a2x_next;
    logic [DATA_W-1:0]      bx1_reg,       bx1_next;
    logic [DATA_W-1:0]      bx2_reg,       bx2_next;
    logic                   push11_reg,    push11_next;
    logic                   pushedge_reg,  pushedge_next;
    logic                   push22_reg,    push22_next;
    logic                   out_valid_reg, out_valid_next;
    logic [4*ACC_W-1:0]     out_c_reg,     out_c_next;

    logic                   accept;
    logic                   capture;
    logic                   feeding_next;

    // ------------------------------------------------------------------------
    // Operand source
    // ------------------------------------------------------------------------
    // The first feed cycle is computed on the accept edge itself, before the
    // operand registers hold the new pair, so while IDLE the tables are read
    // straight from the input bus. The only way out of IDLE is an accept,
    // hence the IDLE-time value is used exactly when it is the right one.
    logic [OP_W-1:0]        src_a;
    logic [OP_W-1:0]        src_b;

    assign src_a = (state_reg == ST_IDLE) ? in_a : op_a_reg;
    assign src_b = (state_reg == ST_IDLE) ? in_b : op_b_reg;

    // ------------------------------------------------------------------------
    // Per-feed-cycle lookup tables
    // ------------------------------------------------------------------------
    // row1_tab[c] = A[0][c]      col1_tab[c] = B[c][0]      (c < K)
    // row2_tab[c] = A[1][c-1]    col2_tab[c] = B[c-1][1]    (1 <= c <= K)
    // The one-cycle offset of row 2 / column 2 is the array skew.
    logic [DATA_W-1:0]      row1_tab [CNT_DEPTH];
    logic [DATA_W-1:0]      row2_tab [CNT_DEPTH];
    logic [DATA_W-1:0]      col1_tab [CNT_DEPTH];
    logic [DATA_W-1:0]      col2_tab [CNT_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < CNT_DEPTH; gi++) begin : g_tab
            if (gi < K) begin : g_first
                assign row1_tab[gi] = src_a[gi*DATA_W +: DATA_W];
                assign col1_tab[gi] = src_b[gi*DATA_W +: DATA_W];
            end else begin : g_first_zero
                assign row1_tab[gi] = '0;
                assign col1_tab[gi] = '0;
            end

            if ((gi >= 1) && (gi <= K)) begin : g_second
                assign row2_tab[gi] = src_a[(K+gi-1)*DATA_W +: DATA_W];
                assign col2_tab[gi] = src_b[(K+gi-1)*DATA_W +: DATA_W];
            end else begin : g_second_zero
                assign row2_tab[gi] = '0;
                assign col2_tab[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        op_a_next      = op_a_reg;
        op_b_next      = op_b_reg;
        out_valid_next = out_valid_reg;
        out_c_next     = out_c_reg;
        accept         = 1'b0;
        capture        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_FEED;
                    cnt_next   = '0;
                    op_a_next  = in_a;
                    op_b_next  = in_b;
                end
            end

            ST_FEED: begin
                if (cnt_reg == FEED_LAST_C) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end

            ST_DRAIN: begin
                if (cnt_reg == DRAIN_LAST_C) begin
                    capture        = 1'b1;
                    state_next     = ST_DONE;
                    cnt_next       = '0;
                    out_valid_next = 1'b1;
                    out_c_next     = {c11, c12, c21, c22};
                end else begin
                    cnt_next       = cnt_reg + CNT_ONE;
                end
            end

            ST_DONE: begin
                // out_c_reg is left untouched here, so the result is stable
                // for as long as the consumer stalls.
                if (out_ready) begin
                    state_next     = ST_IDLE;
                    out_valid_next = 1'b0;
                end
            end

            default: begin
                state_next     = ST_IDLE;
                cnt_next       = '0;
                out_valid_next = 1'b0;
            end
        endcase

        // Streams and strobes are registered from the next-state values so
        // that the value belonging to feed cycle cnt appears during cnt.
        feeding_next  = (state_next == ST_FEED);
        a1x_next      = feeding_next ? row1_tab[cnt_next] : '0;
        bx1_next      = feeding_next ? col1_tab[cnt_next] : '0;
        a2x_next      = feeding_next ? row2_tab[cnt_next] : '0;
        bx2_next      = feeding_next ? col2_tab[cnt_next] : '0;
        push11_next   = feeding_next && (cnt_next == '0);
        pushedge_next = feeding_next && (cnt_next == CNT_ONE);
        push22_next   = feeding_next && (cnt_next == CNT_TWO);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            a1x_reg       <= '0;
            a2x_reg       <= '0;
            bx1_reg       <= '0;
            bx2_reg       <= '0;
            push11_reg    <= 1'b0;
            pushedge_reg  <= 1'b0;
            push22_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_c_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            op_a_reg      <= op_a_next;
            op_b_reg      <= op_b_next;
            a1x_reg       <= a1x_next;
            a2x_reg       <= a2x_next;
            bx1_reg       <= bx1_next;
            bx2_reg       <= bx2_next;
            push11_reg    <= push11_next;
            pushedge_reg  <= pushedge_next;
            push22_reg    <= push22_next;
            out_valid_reg <= out_valid_next;
            out_c_reg     <= out_c_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // in_ready is a decode of the state register, so it is glitch-free and
    // rises the cycle after the result handshake returns the FSM to IDLE.
    assign in_ready  = (state_reg == ST_IDLE);
    assign a1X       = a1x_reg;
    assign a2X       = a2x_reg;
    assign bX1       = bx1_reg;
    assign bX2       = bx2_reg;
    assign push11    = push11_reg;
    assign pushedge  = pushedge_reg;
    assign push22    = push22_reg;
    assign out_valid = out_valid_reg;
    assign out_c     = out_c_reg;

    // accept/capture are kept as named decodes for debug visibility.
    logic unused_decodes;
    assign unused_decodes = accept ^ capture;

endmodule
